// File: rtl/col_normalize.sv
// col_normalize: divides a 4-element complex column by its norm, producing SCALE-scaled fixed-point elements.
// Define COL_NORMALIZE_ROUND_EN to round half away from zero instead of truncating toward zero.
module col_normalize #(
  parameter int W = 28,
  parameter int SCALE = 10000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [W-1:0] real_1,
  input  logic signed [W-1:0] real_2,
  input  logic signed [W-1:0] real_3,
  input  logic signed [W-1:0] real_4,
  input  logic signed [W-1:0] imag_1,
  input  logic signed [W-1:0] imag_2,
  input  logic signed [W-1:0] imag_3,
  input  logic signed [W-1:0] imag_4,
  input  logic [W-1:0]        norm_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [W-1:0] q_real_1,
  output logic signed [W-1:0] q_real_2,
  output logic signed [W-1:0] q_real_3,
  output logic signed [W-1:0] q_real_4,
  output logic signed [W-1:0] q_imag_1,
  output logic signed [W-1:0] q_imag_2,
  output logic signed [W-1:0] q_imag_3,
  output logic signed [W-1:0] q_imag_4,
  output logic                div_zero
);
  localparam int QW = W + 14;
  localparam int CW = $clog2(QW);
  localparam logic [W-1:0] MAXV = {1'b0, {(W-1){1'b1}}};
  typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;
  state_t state, state_nx;
  logic signed [W-1:0] e [8];
  logic signed [W-1:0] q [8];
  logic [W-1:0] norm, rem, rem_nx, qmag;
  logic [QW-2:0] quo;
  logic [CW-1:0] cnt;
  logic [2:0] idx;
  logic [W:0] ext, mag, trial;
  logic [QW-1:0] num, qfull;
  logic ge, last;
  // Element magnitude is formed in W+1 bits so the most negative input is representable.
  assign ext = {e[idx][W-1], e[idx]};
  assign mag = ext[W] ? -ext : ext;
`ifdef COL_NORMALIZE_ROUND_EN
  assign num = QW'(mag) * QW'(SCALE) + QW'(norm >> 1);
`else
  assign num = QW'(mag) * QW'(SCALE);
`endif
  assign trial = {rem, num[CW'(QW-1) - cnt]};
  assign ge = trial >= {1'b0, norm};
  assign rem_nx = ge ? W'(trial - {1'b0, norm}) : trial[W-1:0];
  assign qfull = {quo, ge};
  assign qmag = (qfull > QW'(MAXV)) ? MAXV : qfull[W-1:0];
  assign last = cnt == CW'(QW-1);
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = in_valid ? ((norm_in != '0) ? DIV : DONE) : IDLE;
      DIV: state_nx = (last && idx == 3'd7) ? DONE : DIV;
      DONE: state_nx = out_ready ? IDLE : DONE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin
        e[i] <= '0;
        q[i] <= '0;
      end
      norm <= '0;
      rem <= '0;
      quo <= '0;
      cnt <= '0;
      idx <= '0;
      div_zero <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      e[0] <= real_1; e[1] <= imag_1; e[2] <= real_2; e[3] <= imag_2;
      e[4] <= real_3; e[5] <= imag_3; e[6] <= real_4; e[7] <= imag_4;
      for (int i = 0; i < 8; i++) q[i] <= '0;
      norm <= norm_in;
      div_zero <= norm_in == '0;
      rem <= '0;
      quo <= '0;
      cnt <= '0;
      idx <= '0;
    end else if (state == DIV) begin
      if (last) begin
        q[idx] <= e[idx][W-1] ? -qmag : qmag;
        rem <= '0;
        quo <= '0;
        cnt <= '0;
        idx <= idx + 3'd1;
      end else begin
        rem <= rem_nx;
        quo <= {quo[QW-3:0], ge};
        cnt <= cnt + CW'(1);
      end
    end
  end
  assign q_real_1 = q[0];
  assign q_imag_1 = q[1];
  assign q_real_2 = q[2];
  assign q_imag_2 = q[3];
  assign q_real_3 = q[4];
  assign q_imag_3 = q[5];
  assign q_real_4 = q[6];
  assign q_imag_4 = q[7];
endmodule

// File: doc/col_normalize.md
COL_NORMALIZE -- requirements
Module: col_normalize

Interface
REQ-001 SHALL have parameter W, default 28: bit width of each real/imag element and of each output element.
REQ-002 SHALL have parameter SCALE, default 10000: fixed-point output scale, so unit magnitude maps to SCALE.
REQ-003 SHALL have derived localparam QW = W+14: numerator/quotient width, sized to hold |x|*SCALE.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 in_valid  input  1  column vector and norm presented.
REQ-007 in_ready  output  1  block can accept a vector.
REQ-008 real_1..real_4, imag_1..imag_4  input  W each, signed  column elements x_k.
REQ-009 norm_in  input  W, unsigned  column norm, same scale as elements.
REQ-010 out_valid  output  1  normalized vector valid.
REQ-011 out_ready  input  1  downstream accepts result.
REQ-012 q_real_1..q_real_4, q_imag_1..q_imag_4  output  W each, signed  normalized elements.
REQ-013 div_zero  output  1  result came from norm_in == 0.

Function
REQ-014 SHALL transfer input when in_valid && in_ready on a rising edge; all 9 inputs registered that edge.
REQ-015 SHALL transfer output when out_valid && out_ready on a rising edge.
REQ-016 SHALL implement FSM IDLE -> DIV -> DONE -> IDLE; in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-017 IDLE: on input transfer go to DIV if norm_in != 0, else DONE directly.
REQ-018 DIV: one shared restoring divider, one quotient bit per cycle, elements in order real_1, imag_1, ..., real_4, imag_4; QW cycles per element.
REQ-019 SHALL leave DIV for DONE exactly 8*QW cycles after the accepting edge (336 for W=28); out_valid visible the cycle after the last DIV cycle.
REQ-020 Per element: numerator = |x_k| * SCALE (QW bits, no overflow); quotient = floor(numerator / norm); sign of x_k reapplied.
REQ-021 SHALL saturate each signed result to [-(2^(W-1)-1), 2^(W-1)-1] if the magnitude exceeds W-1 bits.
REQ-022 Zero norm: all q outputs = 0, div_zero = 1; otherwise div_zero = 0.
REQ-023 DONE: outputs and div_zero held stable until transfer; on transfer go to IDLE (in_ready rises next cycle; no same-cycle re-accept).
REQ-024 Input changes while in DIV or DONE SHALL be ignored.
REQ-025 Most-negative input -2^(W-1) SHALL be handled (|x| formed in W+1 bits).

Reset
REQ-026 rst_n low SHALL immediately force IDLE, in_ready = 1 after release, out_valid = 0, div_zero = 0, all q outputs = 0, divider registers = 0.
REQ-027 Reset asserted mid-DIV or in DONE SHALL abort the operation; no partial result ever appears on out_valid.

Configuration
REQ-028 Macro COL_NORMALIZE_ROUND_EN: when defined, numerator = |x_k|*SCALE + floor(norm/2) (round half away from zero); when undefined, truncate toward zero per REQ-020. Latency and saturation unchanged.

Verification
REQ-029 norm_in=5000, real_1=3000, imag_1=4000, rest 0 -> after 336 cycles out_valid=1, q_real_1=6000, q_imag_1=8000, others 0, div_zero=0.
REQ-030 norm_in=3, real_1=1, imag_1=-1, rest 0 -> q_real_1=3333, q_imag_1=-3333 without macro; 3333, -3333 with macro; norm_in=3, real_1=2 -> 6666 without, 6667 with.
REQ-031 norm_in=0, any elements -> out_valid exactly 1 cycle after accept, all q=0, div_zero=1.
REQ-032 norm_in=1, real_1=-2^27 -> q_real_1 saturates to -(2^27-1); real_2=2^27-1 -> q_real_2 = 2^27-1.
REQ-033 out_ready held 0 for 20 cycles in DONE -> outputs stable, in_ready=0; then out_ready=1 -> transfer, in_ready=1 next cycle.
REQ-034 rst_n pulsed low at cycle 100 of DIV -> out_valid=0, in_ready=1 after release; new vector then yields correct result with full 336-cycle latency.
